// File: rtl/audio_mixer_tdm.sv
// audio_mixer_tdm: time-multiplexed stereo mixer.
// A sample strobe snapshots every channel. One shared multiply-accumulate
// then processes one channel per clock into the left/right accumulators,
// and a final cycle rescales, saturates and registers the stereo pair.
//
// Handshake: ce_sample is a one-cycle request that is accepted only while
// busy is low (a strobe seen while busy is dropped and sets the sticky
// overrun flag). out_valid is a one-cycle pulse, not held, and the
// consumer has no way to stall it. audio_l/audio_r and clip_l/clip_r are
// valid in that cycle, and they hold their values until the next pulse.
module audio_mixer_tdm #(
  parameter int NCH    = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 5
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ce_sample,
  input  logic [NCH*IN_W-1:0]      ch_data,
  input  logic [NCH*GAIN_W-1:0]    ch_gain,
  input  logic [NCH*2-1:0]         ch_route,
  input  logic                     master_mute,
  input  logic                     clear_overrun,
  output logic signed [OUT_W-1:0]  audio_l,
  output logic signed [OUT_W-1:0]  audio_r,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     clip_l,
  output logic                     clip_r
);

  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PROD_W = IN_W + GAIN_W + 1;
  // Wide enough that summing NCH full-scale products never wraps.
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(NCH) + 1;
  // Accumulator width plus headroom for the output up-shift.
  localparam int SC_W   = ACC_W + OUT_W - IN_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);
  localparam logic signed [SC_W-1:0] SAT_MAX =
    {{(SC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [IN_W-1:0]   snap_data  [NCH];
  logic        [GAIN_W-1:0] snap_gain  [NCH];
  logic        [1:0]        snap_route [NCH];

  logic        [CW-1:0]     ch_idx;
  logic signed [ACC_W-1:0]  acc_l, acc_r;

  logic signed [IN_W-1:0]   cur_data;
  logic        [GAIN_W-1:0] cur_gain;
  logic        [1:0]        cur_route;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic        [OUT_W:0]    sat_l, sat_r;

  // Rescale an accumulator to output units and clamp it; MSB of the result is the clip flag.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [SC_W-1:0] sc;
    sc = SC_W'(acc);
    sc = sc >>> (GAIN_W - 1);
    sc = sc <<< (OUT_W - IN_W);
    if (sc > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (sc < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, sc[OUT_W-1:0]};
    end
  endfunction

  // Select the current channel and form its gain product and saturated sums.
  always_comb begin
    cur_data  = snap_data[ch_idx];
    cur_gain  = snap_gain[ch_idx];
    cur_route = snap_route[ch_idx];
    // Gain is unsigned, so a zero sign bit is prepended before the signed multiply.
    prod      = PROD_W'(cur_data) * PROD_W'($signed({1'b0, cur_gain}));
    prod_ext  = ACC_W'(prod);
    sat_l     = saturate(acc_l);
    sat_r     = saturate(acc_r);
  end

  // Next-state logic: idle until a strobe, one ACC cycle per channel, then one SAT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ce_sample) state_d = ST_ACC;
      ST_ACC:  if (ch_idx == LAST_IDX) state_d = ST_SAT;
      ST_SAT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  assign busy = (state_q != ST_IDLE);

  // Datapath: snapshot, accumulate, saturate/register outputs, sticky overrun.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        snap_data[i]  <= '0;
        snap_gain[i]  <= '0;
        snap_route[i] <= '0;
      end
      ch_idx    <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      audio_l   <= '0;
      audio_r   <= '0;
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // A dropped strobe takes priority over a clear arriving in the same cycle.
      if (ce_sample && (state_q != ST_IDLE)) overrun <= 1'b1;
      else if (clear_overrun)                overrun <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ce_sample) begin
            for (int i = 0; i < NCH; i++) begin
              snap_data[i]  <= ch_data[i*IN_W +: IN_W];
              snap_gain[i]  <= ch_gain[i*GAIN_W +: GAIN_W];
              snap_route[i] <= ch_route[i*2 +: 2];
            end
            acc_l  <= '0;
            acc_r  <= '0;
            ch_idx <= '0;
          end
        end
        ST_ACC: begin
          if (cur_route[0]) acc_l <= acc_l + prod_ext;
          if (cur_route[1]) acc_r <= acc_r + prod_ext;
          ch_idx <= ch_idx + 1'b1;
        end
        ST_SAT: begin
          out_valid <= 1'b1;
          if (master_mute) begin
            audio_l <= '0;
            audio_r <= '0;
            clip_l  <= 1'b0;
            clip_r  <= 1'b0;
          end else begin
            audio_l <= sat_l[OUT_W-1:0];
            audio_r <= sat_r[OUT_W-1:0];
            clip_l  <= sat_l[OUT_W];
            clip_r  <= sat_r[OUT_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_tdm.sv
// tb_audio_mixer_tdm: directed and randomized checks of the TDM audio mixer
// against a sum-of-products reference model with floor scaling and clamping.
module tb_audio_mixer_tdm;

  localparam int NCH    = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 16;
  localparam int GAIN_W = 5;
  localparam int EW     = 2*OUT_W + 2;

  logic                    clk_sys;
  logic                    reset_n;
  logic                    ce_sample;
  logic [NCH*IN_W-1:0]     ch_data;
  logic [NCH*GAIN_W-1:0]   ch_gain;
  logic [NCH*2-1:0]        ch_route;
  logic                    master_mute;
  logic                    clear_overrun;
  logic signed [OUT_W-1:0] audio_l;
  logic signed [OUT_W-1:0] audio_r;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;
  logic                    clip_l;
  logic                    clip_r;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  audio_mixer_tdm #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ce_sample     (ce_sample),
    .ch_data       (ch_data),
    .ch_gain       (ch_gain),
    .ch_route      (ch_route),
    .master_mute   (master_mute),
    .clear_overrun (clear_overrun),
    .audio_l       (audio_l),
    .audio_r       (audio_r),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun),
    .clip_l        (clip_l),
    .clip_r        (clip_r)
  );

  // Clock generation.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Compare one value and record the outcome.
  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference mix: per side, sum data*gain of routed channels, floor-divide by unity
  // gain, scale to output width, clamp. Packed as {left, right, clip_l, clip_r}.
  function automatic logic [EW-1:0] model(input logic [NCH*IN_W-1:0] d,
                                          input logic [NCH*GAIN_W-1:0] g,
                                          input logic [NCH*2-1:0] r,
                                          input logic mute);
    longint sum_l, sum_r, p, lo, hi, vl, vr;
    logic signed [IN_W-1:0] s;
    logic [GAIN_W-1:0] gg;
    logic cl, cr;
    sum_l = 0;
    sum_r = 0;
    for (int i = 0; i < NCH; i++) begin
      s  = d[i*IN_W +: IN_W];
      gg = g[i*GAIN_W +: GAIN_W];
      p  = longint'(s) * longint'(gg);
      if (r[2*i])   sum_l += p;
      if (r[2*i+1]) sum_r += p;
    end
    hi = (longint'(1) << (OUT_W-1)) - 1;
    lo = -(longint'(1) << (OUT_W-1));
    vl = (sum_l >>> (GAIN_W-1)) * (longint'(1) << (OUT_W-IN_W));
    vr = (sum_r >>> (GAIN_W-1)) * (longint'(1) << (OUT_W-IN_W));
    cl = (vl > hi) || (vl < lo);
    cr = (vr > hi) || (vr < lo);
    if (vl > hi) vl = hi;
    if (vl < lo) vl = lo;
    if (vr > hi) vr = hi;
    if (vr < lo) vr = lo;
    if (mute) return '0;
    return {OUT_W'(vl), OUT_W'(vr), cl, cr};
  endfunction

  // Monitor: every out_valid pops the oldest expectation and compares.
  always @(negedge clk_sys) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got l=%0h r=%0h with no pending expectation", audio_l, audio_r);
      end else begin
        check("mix_out{l,r,clip_l,clip_r}", longint'({audio_l, audio_r, clip_l, clip_r}), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic clear_chans();
    ch_data  = '0;
    ch_gain  = '0;
    ch_route = '0;
  endtask

  task automatic set_ch(input int i, input logic [IN_W-1:0] d,
                        input logic [GAIN_W-1:0] g, input logic [1:0] r);
    ch_data[i*IN_W +: IN_W]     = d;
    ch_gain[i*GAIN_W +: GAIN_W] = g;
    ch_route[i*2 +: 2]          = r;
  endtask

  // Driver: raise ce_sample for one cycle (called at a negedge); optionally log the expectation.
  task automatic send(input logic mute, input bit expect_out);
    master_mute = mute;
    ce_sample   = 1'b1;
    if (expect_out) exp_q.push_back(model(ch_data, ch_gain, ch_route, mute));
    @(negedge clk_sys);
    ce_sample = 1'b0;
  endtask

  // Wait (bounded) for out_valid; report negedges since the strobe edge and busy cycles seen.
  task automatic wait_done(input int start, output int lat, output int busy_n);
    lat    = start;
    busy_n = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_n++;
      @(negedge clk_sys);
      lat++;
    end
  endtask

  // One full transaction with latency and busy-window checks.
  task automatic run(input logic mute, input string name);
    int lat, bn;
    send(mute, 1'b1);
    wait_done(1, lat, bn);
    check({name, "_latency"}, lat, 6);
    check({name, "_busy_cycles"}, bn, 5);
    check({name, "_busy_at_valid"}, busy, 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int lat, bn, nv;
    reset_n       = 1'b0;
    ce_sample     = 1'b0;
    master_mute   = 1'b0;
    clear_overrun = 1'b0;
    clear_chans();
    repeat (3) @(negedge clk_sys);
    check("reset_audio", longint'({audio_l, audio_r}), 0);
    check("reset_flags", longint'({out_valid, busy, overrun, clip_l, clip_r}), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Unity gain, left only.
    clear_chans();
    set_ch(0, 16'h1000, 5'd16, 2'b01);
    run(1'b0, "unity_l");

    // Half gain to both sides, then truncation toward -inf.
    clear_chans();
    set_ch(1, 16'h2000, 5'd8, 2'b11);
    run(1'b0, "half_gain");
    set_ch(1, 16'hFFFF, 5'd8, 2'b11);
    run(1'b0, "trunc_neg");

    // Positive saturation, then clip flags drop on a small mix.
    for (int i = 0; i < NCH; i++) set_ch(i, 16'h7000, 5'd16, 2'b11);
    run(1'b0, "pos_sat");
    clear_chans();
    set_ch(0, 16'h0100, 5'd16, 2'b11);
    run(1'b0, "clip_release");

    // Negative saturation, then the same mix muted.
    clear_chans();
    set_ch(0, 16'h8000, 5'd31, 2'b01);
    run(1'b0, "neg_sat");
    run(1'b1, "muted");
    master_mute = 1'b0;

    // Dropped strobe while busy, plus input changes after the snapshot.
    clear_chans();
    set_ch(0, 16'h1234, 5'd16, 2'b11);
    set_ch(2, 16'h0800, 5'd8, 2'b10);
    send(1'b0, 1'b1);
    @(negedge clk_sys);
    ch_data   = {16'h7FFF, 16'h8000, 16'h5555, 16'hAAAA};
    ch_gain   = '1;
    ce_sample = 1'b1;
    @(negedge clk_sys);
    ce_sample = 1'b0;
    nv = 0;
    repeat (12) begin
      if (out_valid) nv++;
      @(negedge clk_sys);
    end
    check("overrun_single_valid", nv, 1);
    check("overrun_set", overrun, 1);
    repeat (3) @(negedge clk_sys);
    check("overrun_sticky", overrun, 1);
    clear_overrun = 1'b1;
    @(negedge clk_sys);
    clear_overrun = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Clear and a new overrun in the same cycle: the set wins.
    clear_chans();
    set_ch(1, 16'h0321, 5'd16, 2'b01);
    send(1'b0, 1'b1);
    ce_sample     = 1'b1;
    clear_overrun = 1'b1;
    @(negedge clk_sys);
    ce_sample     = 1'b0;
    clear_overrun = 1'b0;
    check("overrun_set_wins", overrun, 1);
    wait_done(2, lat, bn);
    check("set_wins_latency", lat, 6);
    clear_overrun = 1'b1;
    @(negedge clk_sys);
    clear_overrun = 1'b0;
    check("overrun_cleared2", overrun, 0);

    // Strobe in the out_valid cycle is accepted (back-to-back).
    clear_chans();
    set_ch(3, 16'h0400, 5'd16, 2'b01);
    run(1'b0, "b2b_first");
    set_ch(3, 16'hFC00, 5'd16, 2'b10);
    run(1'b0, "b2b_second");
    check("b2b_no_overrun", overrun, 0);

    // Reset during ACC aborts the mix with no out_valid.
    set_ch(3, 16'h0400, 5'd16, 2'b11);
    send(1'b0, 1'b0);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("async_reset_audio", longint'({audio_l, audio_r}), 0);
    check("async_reset_flags", longint'({out_valid, busy, overrun, clip_l, clip_r}), 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (out_valid) nv++;
    end
    check("reset_abort_no_valid", nv, 0);
    run(1'b0, "after_reset");

    // Randomized mixes, occasionally muted, with random idle gaps.
    repeat (40) begin
      for (int i = 0; i < NCH; i++)
        set_ch(i, 16'($urandom), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      run($urandom_range(0, 7) == 0, "random");
      master_mute = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end

    repeat (4) @(negedge clk_sys);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
